// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_pkg: shared ALU opcodes, sequencer FSM states and command packing width.
package alu_pkg;
  localparam logic [2:0] AND = 3'b000, XOR = 3'b001, ADD = 3'b010, MUL = 3'b011, SUB = 3'b100, DIV = 3'b101;
  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
  function automatic int cmd_w(input int width);
    return 3 + 2 * (width + 1) + 6;
  endfunction
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command channel, ALU drive/return and result channel.
interface alu_cmd_sequencer_if #(parameter int width = 4);
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_opcode;
  logic [width:0]   cmd_A, cmd_B;
  logic             cmd_Cin, cmd_full_adder, cmd_red_A, cmd_red_B, cmd_bypass_A, cmd_bypass_B;
  logic [2:0]       alu_opcode;
  logic [width:0]   alu_A, alu_B;
  logic             alu_Cin, alu_full_adder, alu_red_A, alu_red_B, alu_bypass_A, alu_bypass_B;
  logic [2*width:0] alu_out;
  logic             alu_odd_parity, alu_invalid;
  logic             res_valid, res_ready;
  logic [2*width:0] res_out;
  logic             res_odd_parity, res_invalid;
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_A, cmd_B, cmd_Cin, cmd_full_adder, cmd_red_A, cmd_red_B, cmd_bypass_A, cmd_bypass_B,
    output cmd_ready,
    output alu_opcode, alu_A, alu_B, alu_Cin, alu_full_adder, alu_red_A, alu_red_B, alu_bypass_A, alu_bypass_B,
    input  alu_out, alu_odd_parity, alu_invalid, res_ready,
    output res_valid, res_out, res_odd_parity, res_invalid
  );
  modport master (
    output cmd_valid, cmd_opcode, cmd_A, cmd_B, cmd_Cin, cmd_full_adder, cmd_red_A, cmd_red_B, cmd_bypass_A, cmd_bypass_B,
    input  cmd_ready,
    input  alu_opcode, alu_A, alu_B, alu_Cin, alu_full_adder, alu_red_A, alu_red_B, alu_bypass_A, alu_bypass_B,
    output alu_out, alu_odd_parity, alu_invalid, res_ready,
    input  res_valid, res_out, res_odd_parity, res_invalid
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO, wrap-bit pointers, push refused when full.
module alu_cmd_fifo #(
  parameter int DW    = 19,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr, rd;
  logic          do_push, do_pop;
  assign full    = (wr ^ rd) == {1'b1, {AW{1'b0}}};
  assign empty   = wr == rd;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd[AW-1:0]];
  always_ff @(posedge clk)
    if (do_push) mem[wr[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, drives the ALU from registers, holds
// them SETTLE cycles, then captures the result behind a valid/ready handshake.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int width  = 4,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_sequencer_if.slave  bus,
  output logic [7:0]          invalid_count,
  output logic                busy
);
  localparam int CW = cmd_w(width);
  localparam int SW = $clog2(SETTLE + 1);
  state_t        state, state_nx;
  logic [SW-1:0] settle_cnt;
  logic          full, empty, push, pop, hs, capture, settled;
  logic [CW-1:0] din, dout;
  assign push          = bus.cmd_valid && !full;
  assign bus.cmd_ready = !full;
  assign busy          = !empty || state != IDLE;
  assign din = {bus.cmd_opcode, bus.cmd_A, bus.cmd_B, bus.cmd_Cin, bus.cmd_full_adder,
                bus.cmd_red_A, bus.cmd_red_B, bus.cmd_bypass_A, bus.cmd_bypass_B};
  alu_cmd_fifo #(.DW(CW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .din(din), .dout(dout), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (empty ? IDLE : DRIVE) :
               state == DRIVE ? (settled ? HOLD : DRIVE) :
               state == HOLD  ? (hs ? (empty ? IDLE : DRIVE) : HOLD) : IDLE;
  end
  always_comb begin
    settled = settle_cnt == SW'(1);
    hs      = state == HOLD && bus.res_valid && bus.res_ready;
    pop     = !empty && (state == IDLE || hs);
    capture = state == DRIVE && settled;
  end
  // ALU drive registers only change on a pop, so the ALU sees no toggling while idle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {bus.alu_opcode, bus.alu_A, bus.alu_B, bus.alu_Cin, bus.alu_full_adder,
       bus.alu_red_A, bus.alu_red_B, bus.alu_bypass_A, bus.alu_bypass_B} <= '0;
      settle_cnt         <= '0;
      bus.res_valid      <= 1'b0;
      bus.res_out        <= '0;
      bus.res_odd_parity <= 1'b0;
      bus.res_invalid    <= 1'b0;
      invalid_count      <= '0;
    end else begin
      if (pop) begin
        {bus.alu_opcode, bus.alu_A, bus.alu_B, bus.alu_Cin, bus.alu_full_adder,
         bus.alu_red_A, bus.alu_red_B, bus.alu_bypass_A, bus.alu_bypass_B} <= dout;
        settle_cnt <= SW'(SETTLE);
      end else if (state == DRIVE) settle_cnt <= settle_cnt - 1'b1;
      if (capture) begin
        bus.res_valid      <= 1'b1;
        bus.res_out        <= bus.alu_out;
        bus.res_odd_parity <= bus.alu_odd_parity;
        bus.res_invalid    <= bus.alu_invalid;
        if (bus.alu_invalid && invalid_count != 8'hFF) invalid_count <= invalid_count + 1'b1;
      end else if (hs) bus.res_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: vector table, corner sequences and a random scoreboard run
// against a behavioural ALU and an in-order result model.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;
  typedef struct packed {
    logic [2:0] op;
    logic [4:0] a, b;
    logic cin, fa, ra, rb, ba, bb;
  } cmd_t;
  typedef struct {
    cmd_t c;
    logic [8:0] e_out;
    logic e_par, e_inv;
    int e_cnt;
  } vec_t;
  logic clk = 0, rst_n = 0;
  logic [7:0] cnt0, cnt3;
  logic busy0, busy3;
  int n_chk = 0, n_fail = 0, exp_cnt = 0;
  logic [10:0] q[$];
  always #5 clk = ~clk;
  alu_cmd_sequencer_if #(.width(4)) b0();
  alu_cmd_sequencer_if #(.width(4)) b3();
  alu_cmd_sequencer #(.width(4), .DEPTH(4), .SETTLE(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0), .invalid_count(cnt0), .busy(busy0));
  alu_cmd_sequencer #(.width(4), .DEPTH(4), .SETTLE(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3), .invalid_count(cnt3), .busy(busy3));
  function automatic logic [10:0] alu_ref(input cmd_t c);
    logic [8:0] o;
    logic inv;
    inv = (c.op == MUL || c.op == DIV) && (c.ra || c.rb || c.ba || c.bb);
    case (c.op)
      AND: o = {4'd0, c.a & c.b};
      XOR: o = {4'd0, c.a ^ c.b};
      ADD: o = 9'(c.a) + 9'(c.b) + 9'(c.fa & c.cin);
      MUL: o = 9'(c.a) * 9'(c.b);
      SUB: o = 9'(c.a) - 9'(c.b);
      DIV: begin
        o = c.b == 0 ? 9'd0 : 9'(c.a / c.b);
        inv = inv || c.b == 0;
      end
      default: return {9'd0, 1'b0, 1'b1};
    endcase
    return {o, ~^o, inv};
  endfunction
  assign {b0.alu_out, b0.alu_odd_parity, b0.alu_invalid} = alu_ref(cmd_t'({b0.alu_opcode, b0.alu_A, b0.alu_B,
    b0.alu_Cin, b0.alu_full_adder, b0.alu_red_A, b0.alu_red_B, b0.alu_bypass_A, b0.alu_bypass_B}));
  assign {b3.alu_out, b3.alu_odd_parity, b3.alu_invalid} = alu_ref(cmd_t'({b3.alu_opcode, b3.alu_A, b3.alu_B,
    b3.alu_Cin, b3.alu_full_adder, b3.alu_red_A, b3.alu_red_B, b3.alu_bypass_A, b3.alu_bypass_B}));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic fail_now(input string n);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", n);
  endtask
  task automatic set_cmd0(input cmd_t c);
    {b0.cmd_opcode, b0.cmd_A, b0.cmd_B, b0.cmd_Cin, b0.cmd_full_adder, b0.cmd_red_A, b0.cmd_red_B,
     b0.cmd_bypass_A, b0.cmd_bypass_B} = c;
  endtask
  task automatic set_cmd3(input cmd_t c);
    {b3.cmd_opcode, b3.cmd_A, b3.cmd_B, b3.cmd_Cin, b3.cmd_full_adder, b3.cmd_red_A, b3.cmd_red_B,
     b3.cmd_bypass_A, b3.cmd_bypass_B} = c;
  endtask
  task automatic note_push(input cmd_t c);
    logic [10:0] r;
    r = alu_ref(c);
    q.push_back(r);
    if (r[0] && exp_cnt < 255) exp_cnt++;
  endtask
  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_cnt = 0;
    q.delete();
    @(negedge clk);
  endtask
  task automatic run_one(input vec_t v);
    int lat;
    set_cmd0(v.c);
    b0.cmd_valid = 1;
    @(negedge clk);
    b0.cmd_valid = 0;
    lat = 0;
    while (!b0.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 2);
    chk("alu_A_drive", b0.alu_A, v.c.a);
    chk("res_out", b0.res_out, v.e_out);
    chk("res_odd_parity", b0.res_odd_parity, v.e_par);
    chk("res_invalid", b0.res_invalid, v.e_inv);
    chk("invalid_count", cnt0, v.e_cnt);
    b0.res_ready = 1;
    @(negedge clk);
    b0.res_ready = 0;
    chk("res_valid_clear", b0.res_valid, 0);
    chk("busy_after", busy0, 0);
  endtask
  initial begin
    vec_t tv[6];
    cmd_t c;
    logic [31:0] r;
    logic [10:0] e;
    int acc, got, cyc, last, lat;
    logic seen;
    tv[0] = '{cmd_t'{op: ADD, a: 3,     b: 4,     cin: 1, fa: 1, default: 0}, 9'd8,     1'b0, 1'b0, 0};
    tv[1] = '{cmd_t'{op: MUL, a: 3,     b: 5,     ra: 1,  default: 0},        9'd15,    1'b1, 1'b1, 1};
    tv[2] = '{cmd_t'{op: AND, a: 5'h1C, b: 5'h0A, default: 0},                9'h008,   1'b0, 1'b0, 1};
    tv[3] = '{cmd_t'{op: SUB, a: 2,     b: 5,     default: 0},                9'h1FD,   1'b1, 1'b0, 1};
    tv[4] = '{cmd_t'{op: XOR, a: 5'h0F, b: 5'h03, default: 0},                9'h00C,   1'b1, 1'b0, 1};
    tv[5] = '{cmd_t'{op: DIV, a: 20,    b: 0,     default: 0},                9'h000,   1'b1, 1'b1, 2};
    b0.cmd_valid = 0; b0.res_ready = 0; set_cmd0('0);
    b3.cmd_valid = 0; b3.res_ready = 0; set_cmd3('0);
    repeat (2) @(negedge clk);
    chk("rst_res_valid", b0.res_valid, 0);
    chk("rst_alu_A", b0.alu_A, 0);
    chk("rst_invalid_count", cnt0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_cmd_ready", b0.cmd_ready, 1);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_one(tv[i]);
    exp_cnt = 2;
    // SETTLE=3 instance: inputs held three cycles, result four cycles after accept
    set_cmd3(cmd_t'{op: XOR, a: 5'h0F, b: 5'h03, default: 0});
    b3.cmd_valid = 1;
    @(negedge clk);
    b3.cmd_valid = 0;
    lat = 0;
    while (!b3.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat <= 3) chk("s3_alu_A_stable", b3.alu_A, 5'h0F);
      if (lat <= 3) chk("s3_alu_opcode_stable", b3.alu_opcode, XOR);
    end
    chk("s3_latency", lat, 4);
    chk("s3_res_out", b3.res_out, 9'h00C);
    b3.res_ready = 1;
    @(negedge clk);
    b3.res_ready = 0;
    chk("s3_res_valid_clear", b3.res_valid, 0);
    // backpressure: one in HOLD plus DEPTH queued, then drained in order
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      c = cmd_t'{op: ADD, a: 5'(acc + 1), b: 2, default: 0};
      set_cmd0(c);
      b0.cmd_valid = 1;
      if (b0.cmd_ready) begin
        note_push(c);
        acc++;
      end
      @(negedge clk);
    end
    b0.cmd_valid = 0;
    chk("bp_accepted", acc, 5);
    chk("bp_cmd_ready_full", b0.cmd_ready, 0);
    b0.res_ready = 1;
    got = 0; cyc = 0; last = 0;
    while (got < 5 && cyc < 40) begin
      if (b0.res_valid) begin
        e = q.pop_front();
        chk("bp_result", {b0.res_out, b0.res_odd_parity, b0.res_invalid}, e);
        if (got > 0) chk("bp_gap", cyc - last, 2);
        last = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < 5) fail_now("bp_drain");
    b0.res_ready = 0;
    @(negedge clk);
    // random traffic against the in-order model
    q.delete();
    for (int i = 0; i < 500; i++) begin
      r = $urandom;
      c = r[18:0];
      set_cmd0(c);
      b0.cmd_valid = i < 400 ? r[31] : 1'b0;
      b0.res_ready = i < 400 ? r[30:29] != 0 : 1'b1;
      if (b0.res_valid && b0.res_ready) begin
        if (q.size() == 0) fail_now("rnd_unexpected_result");
        else chk("rnd_result", {b0.res_out, b0.res_odd_parity, b0.res_invalid}, q.pop_front());
      end
      if (b0.cmd_valid && b0.cmd_ready) note_push(c);
      @(negedge clk);
    end
    b0.res_ready = 0;
    chk("rnd_drained", q.size(), 0);
    chk("rnd_invalid_count", cnt0, exp_cnt);
    chk("rnd_busy", busy0, 0);
    // saturation of the invalid counter
    do_reset();
    b0.res_ready = 1;
    acc = 0; got = 0; cyc = 0;
    while (got < 260 && cyc < 2000) begin
      r = $urandom;
      c = r[18:0];
      c.op = 3'b110;
      set_cmd0(c);
      b0.cmd_valid = acc < 260;
      if (b0.cmd_valid && b0.cmd_ready) acc++;
      if (b0.res_valid) begin
        chk("sat_result", {b0.res_out, b0.res_odd_parity, b0.res_invalid}, {9'd0, 1'b0, 1'b1});
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    b0.cmd_valid = 0;
    b0.res_ready = 0;
    if (got < 260) fail_now("sat_drain");
    chk("sat_invalid_count", cnt0, 255);
    // async reset in DRIVE with two commands queued
    for (int i = 0; i < 3; i++) begin
      set_cmd3(cmd_t'{op: XOR, a: 5'(i + 1), b: 5'h1F, default: 0});
      b3.cmd_valid = 1;
      @(negedge clk);
    end
    b3.cmd_valid = 0;
    chk("pre_reset_busy", busy3, 1);
    chk("pre_reset_alu_A", b3.alu_A, 1);
    #2 rst_n = 0;
    #1;
    chk("async_alu_A", b3.alu_A, 0);
    chk("async_alu_opcode", b3.alu_opcode, 0);
    chk("async_busy", busy3, 0);
    chk("async_cmd_ready", b3.cmd_ready, 1);
    chk("async_cnt0", cnt0, 0);
    @(negedge clk);
    rst_n = 1;
    b3.res_ready = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | b3.res_valid | busy3;
    end
    chk("post_reset_quiet", seen, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
